// File: rtl/imm_pkg.sv
// ============================================================================
//  Module      : imm_pkg
//  Description : Shared kinds, opcodes and FSM states for the immediate encoder.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package imm_pkg;

    // Kind values match the decoder's ImmSrc so the encoder and decoder agree.
    typedef enum logic [2:0] {
        IMM_I  = 3'b000,
        IMM_U  = 3'b001,
        IMM_S  = 3'b010,
        IMM_B  = 3'b011,
        IMM_J  = 3'b100,
        IMM_LI = 3'b101
    } imm_kind_e;

    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_OPIMM = 7'b0010011;
    localparam logic [2:0] F3_ADDI  = 3'b000;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FIRST = 2'd2
    } enc_state_e;

endpackage

`default_nettype wire

// File: rtl/imm_field_pack.sv
// ============================================================================
//  Module      : imm_field_pack
//  Description : Packs an immediate into an RV32I instruction template with
//                range/alignment checking. Purely combinational.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imm_field_pack
    import imm_pkg::*;
(
    input  logic [2:0]  i_kind,
    input  logic [31:0] i_base,
    input  logic [31:0] i_imm,
    output logic [31:0] o_instr,
    output logic        o_err
);

    logic w_fits12;
    logic w_fits20;

    assign w_fits12 = (&i_imm[31:11]) | ~(|i_imm[31:11]);
    assign w_fits20 = (&i_imm[31:19]) | ~(|i_imm[31:19]);

    always_comb begin
        o_instr = i_base;
        o_err   = 1'b0;
        case (i_kind)
            IMM_I: begin
                if (w_fits12) o_instr[31:20] = i_imm[11:0];
                else          o_err = 1'b1;
            end
            IMM_U: begin
                if (i_imm[11:0] == 12'd0) o_instr[31:12] = i_imm[31:12];
                else                      o_err = 1'b1;
            end
            IMM_S: begin
                if (w_fits12) begin
                    o_instr[31:25] = i_imm[11:5];
                    o_instr[11:7]  = i_imm[4:0];
                end else begin
                    o_err = 1'b1;
                end
            end
            IMM_B: begin
                if (w_fits12) begin
                    o_instr[31]    = i_imm[11];
                    o_instr[7]     = i_imm[10];
                    o_instr[30:25] = i_imm[9:4];
                    o_instr[11:8]  = i_imm[3:0];
                end else begin
                    o_err = 1'b1;
                end
            end
            IMM_J: begin
                if (w_fits20) begin
                    o_instr[31]    = i_imm[19];
                    o_instr[19:12] = i_imm[18:11];
                    o_instr[20]    = i_imm[10];
                    o_instr[30:21] = i_imm[9:0];
                end else begin
                    o_err = 1'b1;
                end
            end
            // LI is expanded by the caller; it is never an error here.
            IMM_LI:  o_err = 1'b0;
            default: o_err = 1'b1;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/imm_encoder.sv
// ============================================================================
//  Module      : imm_encoder
//  Description : Streams encoded instruction words; expands LI into LUI+ADDI.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imm_encoder
    import imm_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_kind,
    input  logic [31:0] in_base,
    input  logic [31:0] in_imm,
    input  logic [4:0]  in_rd,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        out_err,
    output logic        out_last
);

    enc_state_e  state_q, state_d;
    logic [31:0] out_instr_q, out_instr_d;
    logic        out_err_q, out_err_d;
    logic        out_last_q, out_last_d;
    logic [31:0] pend_q, pend_d;

    logic [31:0] w_pack_instr;
    logic        w_pack_err;
    logic [11:0] w_lo;
    logic [19:0] w_hi;
    logic [31:0] w_lui;
    logic [31:0] w_addi_x0;
    logic [31:0] w_addi_rd;
    logic        w_load;

    imm_field_pack u_pack (
        .i_kind  (in_kind),
        .i_base  (in_base),
        .i_imm   (in_imm),
        .o_instr (w_pack_instr),
        .o_err   (w_pack_err)
    );

    // ADDI sign-extends lo, so hi absorbs a borrow when lo is negative.
    assign w_lo      = in_imm[11:0];
    assign w_hi      = in_imm[31:12] + {19'd0, in_imm[11]};
    assign w_lui     = {w_hi, in_rd, OP_LUI};
    assign w_addi_x0 = {w_lo, 5'd0, F3_ADDI, in_rd, OP_OPIMM};
    assign w_addi_rd = {w_lo, in_rd, F3_ADDI, in_rd, OP_OPIMM};

    assign in_ready  = (state_q == ST_EMPTY) || ((state_q == ST_ONE) && out_ready);
    assign out_valid = (state_q != ST_EMPTY);
    assign out_instr = out_instr_q;
    assign out_err   = out_err_q;
    assign out_last  = out_last_q;

    always_comb begin
        state_d     = state_q;
        out_instr_d = out_instr_q;
        out_err_d   = out_err_q;
        out_last_d  = out_last_q;
        pend_d      = pend_q;
        w_load      = 1'b0;

        case (state_q)
            ST_EMPTY: w_load = in_valid;
            ST_ONE: begin
                if (out_ready) begin
                    if (in_valid) w_load  = 1'b1;
                    else          state_d = ST_EMPTY;
                end
            end
            ST_FIRST: begin
                if (out_ready) begin
                    state_d     = ST_ONE;
                    out_instr_d = pend_q;
                    out_err_d   = 1'b0;
                    out_last_d  = 1'b1;
                end
            end
            default: state_d = ST_EMPTY;
        endcase

        if (w_load) begin
            state_d    = ST_ONE;
            out_last_d = 1'b1;
            if (in_kind == IMM_LI) begin
                out_err_d = 1'b0;
                if (w_hi == 20'd0) begin
                    out_instr_d = w_addi_x0;
                end else if (w_lo == 12'd0) begin
                    out_instr_d = w_lui;
                end else begin
                    state_d     = ST_FIRST;
                    out_instr_d = w_lui;
                    out_last_d  = 1'b0;
                    pend_d      = w_addi_rd;
                end
            end else begin
                out_instr_d = w_pack_instr;
                out_err_d   = w_pack_err;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            out_instr_q <= 32'd0;
            out_err_q   <= 1'b0;
            out_last_q  <= 1'b0;
            pend_q      <= 32'd0;
        end else begin
            state_q     <= state_d;
            out_instr_q <= out_instr_d;
            out_err_q   <= out_err_d;
            out_last_q  <= out_last_d;
            pend_q      <= pend_d;
        end
    end

endmodule

`default_nettype wire

// File: doc/imm_encoder.md
Name: imm_encoder

Overview:
Inverse of the core's immediate sign-extend unit. Takes an instruction template plus an immediate value and format, and packs the immediate into the RISC-V instruction fields, with range/alignment checking. Adds a load-immediate pseudo-op that expands any 32-bit constant into a LUI+ADDI sequence. Sits in the test-program generator / boot-ROM builder path and feeds instruction words over a valid/ready stream.

Parameters:
none. All widths are fixed by RV32I.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous reset, active-low
in_valid  in  1  request valid
in_ready  out  1  request accepted when in_valid && in_ready
in_kind  in  3  000 I, 001 U, 010 S, 011 B, 100 J, 101 LI, 110/111 illegal
in_base  in  32  instruction template (opcode, rd, rs1, rs2, funct fields); ignored for LI
in_imm  in  32  immediate, same scaling as the core ImmOp: B and J are halfword counts, U is the full value
in_rd  in  5  destination register, LI only
out_valid  out  1  output word valid
out_ready  in  1  consumer ready
out_instr  out  32  encoded instruction
out_err  out  1  immediate out of range or illegal kind; out_instr = in_base
out_last  out  1  final word of this request

Behaviour:
- Reset (synchronous, rst_n low at the clock edge): out_valid=0, out_instr=0, out_err=0, out_last=0, FSM=EMPTY, pending ADDI discarded.
- FSM states:
  - EMPTY: nothing held.
  - ONE: holding the final word.
  - FIRST: holding a LUI, with the ADDI pre-computed in a pending register.
- in_ready = (state==EMPTY) || (state==ONE && out_ready). Comb from state and out_ready only, never from in_valid.
- Latency: request accepted at edge N gives out_valid=1 after edge N. Single-word requests sustain 1 word/cycle.
- Transitions:
  - EMPTY + accept: go to ONE, or to FIRST for a two-word LI.
  - ONE + out_ready: go to EMPTY, or load the next accepted request.
  - FIRST + out_ready: go to ONE, loading the pending ADDI with out_last=1.
- Outputs stay stable while out_valid && !out_ready.
- Field packing writes the immediate bits and takes all other bits from in_base (immediate bits of in_base are overwritten, not OR'd):
  - I: [31:20]=imm[11:0]
  - U: [31:12]=imm[31:12]
  - S: [31:25]=imm[11:5], [11:7]=imm[4:0]
  - B (halfword h): [31]=h[11], [7]=h[10], [30:25]=h[9:4], [11:8]=h[3:0]
  - J (halfword h): [31]=h[19], [19:12]=h[18:11], [20]=h[10], [30:21]=h[9:0]
- Range checks (failure gives out_err=1, out_last=1, out_instr=in_base):
  - I, S, B: imm[31:11] all equal.
  - J: imm[31:19] all equal.
  - U: imm[11:0]==0.
  - Kinds 110/111 are always errors.
- LI expansion: lo = imm[11:0] (sign-extended); hi = imm[31:12] + imm[11], mod 2^20.
  - LUI = {hi, rd, 7'b0110111}.
  - ADDI = {lo, rs1, 3'b000, rd, 7'b0010011}, with rs1 = rd after a LUI, otherwise x0.
  - hi==0: single ADDI from x0.
  - lo==0 and hi!=0: single LUI.
  - Otherwise two words, LUI first.
  - in_rd==0 is legal and produces normal encoding (a no-op).
- LI never sets out_err.
- Reset during FIRST: the ADDI is never emitted.

Decomposition:
- Package imm_pkg:
  - Kind enum: IMM_I, IMM_U, IMM_S, IMM_B, IMM_J, IMM_LI, sharing values with the decoder ImmSrc.
  - Constants OP_LUI=7'b0110111, OP_OPIMM=7'b0010011, F3_ADDI=3'b000.
  - FSM state enum.
- Sub-module imm_field_pack: purely combinational (kind, base, imm) → (instr, err). It is reused by any future assembler path.
- imm_encoder holds the FSM, the output register, the pending-ADDI register and the LI split logic.

Test Plan:
1. I, base=0x00000093, imm=0xFFFFF800 → one cycle later out_instr=0x80000093, err=0, last=1. Repeat with imm=0x00000800 → err=1, out_instr=0x00000093.
2. B, base=0x00000063, imm=0xFFFFFFFE → 0xFE000EE3. Feeding that into the sign-extend unit with ImmSrc=011 returns 0xFFFFFFFE (round trip).
3. LI, rd=5, imm=0x12345FFF → 0x123462B7 (last=0), then 0xFFF28293 (last=1). in_ready is low while in FIRST.
4. LI, rd=1, imm=0x00000005 → single 0x00500093, last=1. LI, rd=1, imm=0x80000000 → single 0x800000B7.
5. Back-to-back I requests with out_ready=1 → one word per cycle. Hold out_ready=0 for 3 cycles → out_* stable and in_ready=0.
6. rst_n=0 while in FIRST with out_ready=0 → out_valid=0 next cycle, no ADDI ever appears, in_ready=1 after reset is released.
